// File: rtl/iir_coeff_sequencer_if.sv
// Coefficient write channel between the control plane and the IIR coefficient sequencer.
// The master drives the write request; the sequencer (slave) returns ready and an address-error pulse.
interface iir_coeff_sequencer_if #(
    parameter int ADDR_WIDTH  = 3,
    parameter int COEFF_WIDTH = 16
);
    logic                   wr_valid;
    logic                   wr_ready;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [COEFF_WIDTH-1:0] wr_data;
    logic                   wr_err;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready,
        input  wr_err
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready,
        output wr_err
    );
endinterface

// File: rtl/iir_coeff_sequencer.sv
// Stages IIR coefficients in a shadow bank and swaps them into the active bank on a sample
// boundary after a commit, then holds the filter datapath in reset for FLUSH_CYCLES cycles.
module iir_coeff_sequencer #(
    parameter int N            = 2,
    parameter int COEFF_WIDTH  = 16,
    parameter int Q            = 14,
    parameter int ADDR_WIDTH   = 3,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    iir_coeff_sequencer_if.slave         wr_if,
    input  logic                         commit,
    input  logic                         sample_en,
    output logic                         busy,
    output logic                         swapped,
    output logic [COEFF_WIDTH*N-1:0]     packed_a_coeffs,
    output logic [COEFF_WIDTH*(N+1)-1:0] packed_b_coeffs,
    output logic                         filter_rst_n
);
    localparam int NC    = 2 * N + 1;
    localparam int BW    = COEFF_WIDTH * NC;
    localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int LOAD  = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

    localparam logic [ADDR_WIDTH-1:0]  MAX_ADDR   = ADDR_WIDTH'(2 * N);
    localparam logic [COEFF_WIDTH-1:0] UNITY      = COEFF_WIDTH'(1) << Q;
    // Bank layout: a[0..N-1] in the low slots, b[0..N] above them, so b[0] sits at slot N.
    localparam logic [BW-1:0]          UNITY_BANK = BW'(UNITY) << (COEFF_WIDTH * N);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]     shadow_q, shadow_d;
    logic [BW-1:0]     active_q, active_d;
    logic              busy_q, swapped_q, wr_err_q, filter_rst_n_q;
    logic              accept_s, addr_ok_s, swap_s;

    assign wr_if.wr_ready  = (state_q == ST_IDLE);
    assign wr_if.wr_err    = wr_err_q;
    assign busy            = busy_q;
    assign swapped         = swapped_q;
    assign filter_rst_n    = filter_rst_n_q;
    assign packed_a_coeffs = active_q[0 +: COEFF_WIDTH*N];
    assign packed_b_coeffs = active_q[COEFF_WIDTH*N +: COEFF_WIDTH*(N+1)];

    // Next-state logic: commit arms the swap, sample_en performs it, flush counter times the reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        swap_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    state_d = ST_PENDING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (sample_en) begin
                    swap_s  = 1'b1;
                    cnt_d   = CNT_W'(LOAD);
                    state_d = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_IDLE;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shadow write path and whole-bank swap; out-of-range writes are accepted but land nowhere.
    always_comb begin
        accept_s  = wr_if.wr_valid && (state_q == ST_IDLE);
        addr_ok_s = (wr_if.wr_addr <= MAX_ADDR);
        shadow_d  = shadow_q;
        for (int k = 0; k < NC; k++) begin
            if (accept_s && (wr_if.wr_addr == ADDR_WIDTH'(k))) begin
                shadow_d[k*COEFF_WIDTH +: COEFF_WIDTH] = wr_if.wr_data;
            end else begin
                shadow_d[k*COEFF_WIDTH +: COEFF_WIDTH] = shadow_q[k*COEFF_WIDTH +: COEFF_WIDTH];
            end
        end
        if (swap_s) begin
            active_d = shadow_q;
        end else begin
            active_d = active_q;
        end
    end

    // State, banks and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= {CNT_W{1'b0}};
            shadow_q       <= UNITY_BANK;
            active_q       <= UNITY_BANK;
            busy_q         <= 1'b0;
            swapped_q      <= 1'b0;
            wr_err_q       <= 1'b0;
            filter_rst_n_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            busy_q         <= (state_d != ST_IDLE);
            swapped_q      <= swap_s;
            wr_err_q       <= accept_s && !addr_ok_s;
            filter_rst_n_q <= (state_d != ST_FLUSH);
        end
    end
endmodule

// File: tb/tb_iir_coeff_sequencer.sv
// Directed bench for iir_coeff_sequencer: a flush build and a no-flush build run the same stimulus
// and are compared every cycle against a transaction-level model, plus literal spot checks.
module tb_iir_coeff_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid, commit, sample_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;

    logic        busy4, swapped4, frst4, busy0, swapped0, frst0;
    logic [31:0] pa4, pa0;
    logic [47:0] pb4, pb0;

    int n_chk  = 0;
    int n_fail = 0;

    iir_coeff_sequencer_if #(.ADDR_WIDTH(3), .COEFF_WIDTH(16)) if4 ();
    iir_coeff_sequencer_if #(.ADDR_WIDTH(3), .COEFF_WIDTH(16)) if0 ();

    assign if4.wr_valid = wr_valid;
    assign if4.wr_addr  = wr_addr;
    assign if4.wr_data  = wr_data;
    assign if0.wr_valid = wr_valid;
    assign if0.wr_addr  = wr_addr;
    assign if0.wr_data  = wr_data;

    iir_coeff_sequencer #(.N(2), .COEFF_WIDTH(16), .Q(14), .ADDR_WIDTH(3), .FLUSH_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .wr_if(if4.slave), .commit(commit), .sample_en(sample_en),
        .busy(busy4), .swapped(swapped4), .packed_a_coeffs(pa4), .packed_b_coeffs(pb4),
        .filter_rst_n(frst4));

    iir_coeff_sequencer #(.N(2), .COEFF_WIDTH(16), .Q(14), .ADDR_WIDTH(3), .FLUSH_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .wr_if(if0.slave), .commit(commit), .sample_en(sample_en),
        .busy(busy0), .swapped(swapped0), .packed_a_coeffs(pa0), .packed_b_coeffs(pb0),
        .filter_rst_n(frst0));

    always #5 clk = ~clk;

    // Model: index 0 is the 4-cycle flush build, index 1 the no-flush build.
    logic [15:0] ms [2][5];
    logic [15:0] ma [2][5];
    bit          mp [2];
    int          mf [2];
    bit          msw [2];
    bit          merr [2];
    bit          mst [2];

    always @(posedge clk or posedge rst) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int k = 0; k < 5; k++) begin
                    ms[m][k] <= (k == 2) ? 16'h4000 : 16'h0000;
                    ma[m][k] <= (k == 2) ? 16'h4000 : 16'h0000;
                end
                mp[m] <= 1'b0; mf[m] <= 0; msw[m] <= 1'b0; merr[m] <= 1'b0; mst[m] <= 1'b0;
            end else begin
                mst[m]  <= 1'b1;
                merr[m] <= (!mp[m] && mf[m] == 0) && wr_valid && (wr_addr > 3'd4);
                if (!mp[m] && mf[m] == 0 && wr_valid && wr_addr <= 3'd4)
                    ms[m][wr_addr] <= wr_data;
                msw[m] <= 1'b0;
                if (mf[m] > 0) begin
                    mf[m] <= mf[m] - 1;
                end else if (mp[m]) begin
                    if (sample_en) begin
                        for (int k = 0; k < 5; k++) ma[m][k] <= ms[m][k];
                        msw[m] <= 1'b1;
                        mp[m]  <= 1'b0;
                        mf[m]  <= (m == 0) ? 4 : 0;
                    end
                end else if (commit) begin
                    mp[m] <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy4; i++) tick();
        chk("idle_timeout", {63'd0, busy4}, 64'd0);
    endtask

    // Per-cycle comparison of both builds against the model.
    int  lows0 = 0;
    bit  seen0 = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("pa[%0d]", m), m ? pa0 : pa4, {ma[m][1], ma[m][0]});
                chk($sformatf("pb[%0d]", m), m ? pb0 : pb4, {ma[m][4], ma[m][3], ma[m][2]});
                chk($sformatf("busy[%0d]", m), m ? busy0 : busy4, (mp[m] || mf[m] > 0));
                chk($sformatf("ready[%0d]", m), m ? if0.wr_ready : if4.wr_ready, !(mp[m] || mf[m] > 0));
                chk($sformatf("swapped[%0d]", m), m ? swapped0 : swapped4, msw[m]);
                chk($sformatf("wr_err[%0d]", m), m ? if0.wr_err : if4.wr_err, merr[m]);
                chk($sformatf("frst[%0d]", m), m ? frst0 : frst4, (mst[m] && mf[m] == 0));
            end
            if (rst) seen0 = 1'b0;
            else if (frst0) seen0 = 1'b1;
            else if (seen0) lows0++;
        end
    end

    int lows;
    int swaps;

    initial begin
        rst = 1'b1; wr_valid = 1'b0; commit = 1'b0; sample_en = 1'b0;
        wr_addr = 3'd0; wr_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_frst", {63'd0, frst4}, 64'd0);
        chk("rst_pb", {16'd0, pb4}, 64'h0000_0000_4000);
        rst = 1'b0;
        #1;
        chk("release_frst_before_edge", {63'd0, frst4}, 64'd0);
        tick();
        chk("release_frst", {63'd0, frst4}, 64'd1);
        chk("release_busy", {63'd0, busy4}, 64'd0);
        chk("release_ready", {63'd0, if4.wr_ready}, 64'd1);
        chk("release_pa", {32'd0, pa4}, 64'h0);
        chk("release_pb", {16'd0, pb4}, 64'h0000_0000_4000);

        // Load a new set and swap it in five cycles after the commit.
        for (int k = 0; k < 5; k++) begin
            wr_valid = 1'b1;
            wr_addr  = 3'(k);
            wr_data  = (k == 0) ? 16'hC000 : (k == 1) ? 16'h2000 : 16'h1000;
            tick();
        end
        wr_valid = 1'b0;
        commit = 1'b1; tick(); commit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_pa", {32'd0, pa4}, 64'h0);
        end
        sample_en = 1'b1; tick(); sample_en = 1'b0;
        chk("swap_pa", {32'd0, pa4}, 64'h2000_C000);
        chk("swap_pb", {16'd0, pb4}, 64'h1000_1000_1000);
        chk("swap_pulse", {63'd0, swapped4}, 64'd1);
        lows = 0;
        for (int i = 0; i < 20 && !frst4; i++) begin
            lows++;
            chk("flush_busy", {63'd0, busy4}, 64'd1);
            tick();
        end
        chk("flush_len", 64'(lows), 64'd4);
        chk("flush_end_busy", {63'd0, busy4}, 64'd0);

        // Write held through PENDING/FLUSH completes only once back in IDLE.
        commit = 1'b1; tick(); commit = 1'b0;
        wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 16'h0777;
        chk("pend_ready", {63'd0, if4.wr_ready}, 64'd0);
        sample_en = 1'b1; tick(); sample_en = 1'b0;
        chk("reswap_pb", {16'd0, pb4}, 64'h1000_1000_1000);
        for (int i = 0; i < 30 && !if4.wr_ready; i++) tick();
        chk("held_write_ready", {63'd0, if4.wr_ready}, 64'd1);
        tick();
        wr_valid = 1'b0;
        commit = 1'b1; tick(); commit = 1'b0;
        sample_en = 1'b1; tick(); sample_en = 1'b0;
        chk("held_write_pb", {16'd0, pb4}, 64'h1000_1000_0777);
        wait_idle();

        // Out-of-range address: error pulse, no coefficient change.
        wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 16'h7FFF; tick(); wr_valid = 1'b0;
        chk("err_pulse", {63'd0, if4.wr_err}, 64'd1);
        tick();
        chk("err_clear", {63'd0, if4.wr_err}, 64'd0);
        commit = 1'b1; tick(); commit = 1'b0;
        sample_en = 1'b1; tick(); sample_en = 1'b0;
        chk("err_pa", {32'd0, pa4}, 64'h2000_C000);
        chk("err_pb", {16'd0, pb4}, 64'h1000_1000_0777);
        wait_idle();

        // Same-cycle write + commit; a commit during FLUSH is dropped.
        wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'h0123; commit = 1'b1;
        tick();
        wr_valid = 1'b0; commit = 1'b0;
        sample_en = 1'b1; tick(); sample_en = 1'b0;
        swaps = swapped4 ? 1 : 0;
        chk("same_cycle_pb", {16'd0, pb4}, 64'h1000_0123_0777);
        commit = 1'b1; sample_en = 1'b1; tick(); commit = 1'b0; sample_en = 1'b0;
        if (swapped4) swaps++;
        for (int i = 0; i < 40 && busy4; i++) begin
            tick();
            if (swapped4) swaps++;
        end
        for (int i = 0; i < 3; i++) begin
            sample_en = 1'b1; tick(); sample_en = 1'b0;
            if (swapped4) swaps++;
        end
        chk("flush_commit_ignored", 64'(swaps), 64'd1);

        // Reset in the second flush cycle reverts to pass-through immediately.
        commit = 1'b1; tick(); commit = 1'b0;
        sample_en = 1'b1; tick(); sample_en = 1'b0;
        tick();
        chk("midflush_frst", {63'd0, frst4}, 64'd0);
        rst = 1'b1;
        #1;
        chk("midflush_rst_pa", {32'd0, pa4}, 64'h0);
        chk("midflush_rst_pb", {16'd0, pb4}, 64'h0000_0000_4000);
        chk("midflush_rst_busy", {63'd0, busy4}, 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("after_rst_ready", {63'd0, if4.wr_ready}, 64'd1);
        chk("after_rst_busy", {63'd0, busy4}, 64'd0);
        chk("after_rst_frst", {63'd0, frst4}, 64'd1);
        tick(); tick();

        chk("noflush_frst_lows", 64'(lows0), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/iir_coeff_sequencer.md
Name: iir_coeff_sequencer

Overview:
- Controller for the Nth-order direct-form-I IIR filter datapath.
- Accepts coefficient writes from a control interface (register bank or soft CPU) over a valid/ready handshake and stages them in a shadow bank.
- On a commit request, swaps the whole coefficient set into the filter atomically on a sample boundary, then flushes the filter's delay lines for a programmable number of cycles.
- Sits between the control plane and the filter's packed_a_coeffs, packed_b_coeffs and rst_n inputs.

Parameters:
- N, 2, filter order. Gives N a (feedback) coefficients and N+1 b (feed-forward) coefficients.
- COEFF_WIDTH, 16, bits per coefficient (signed, two's complement).
- Q, 14, coefficient scale index. Unity is 1<<Q. Q < COEFF_WIDTH-1.
- ADDR_WIDTH, 3, coefficient address width. 2^ADDR_WIDTH >= 2N+1.
- FLUSH_CYCLES, 4, cycles filter_rst_n is held low after a swap. 0 disables flush.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- wr_valid  in  1  coefficient write request
- wr_ready  out  1  sequencer can accept a write
- wr_addr  in  ADDR_WIDTH  coefficient index
- wr_data  in  COEFF_WIDTH  coefficient value
- wr_err  out  1  one-cycle pulse: accepted write had an out-of-range address
- commit  in  1  request to swap shadow bank into the active bank
- sample_en  in  1  filter sample strobe; swaps occur only on this boundary
- busy  out  1  commit pending or flush in progress
- swapped  out  1  one-cycle pulse after the active bank is updated
- packed_a_coeffs  out  COEFF_WIDTH*N  active a coefficients; a[k] at bits [k*CW +: CW]
- packed_b_coeffs  out  COEFF_WIDTH*(N+1)  active b coefficients; b[k] at bits [k*CW +: CW]
- filter_rst_n  out  1  active-low reset to the filter datapath

Behaviour:
- Address map:
  - 0..N-1 → a[addr]
  - N..2N → b[addr-N]
  - addr > 2N: write accepted and discarded, wr_err=1 on the following cycle.
- Write transfer: occurs on a rising edge with wr_valid && wr_ready. Shadow entry updates at that edge. Active bank is never written directly.
- wr_ready = 1 only in IDLE; 0 in PENDING and FLUSH. Combinational from state.
- Reset (rst high, asynchronous):
  - State = IDLE.
  - Shadow and active banks = pass-through: b[0] = 1<<Q, all other coefficients 0.
  - wr_err=0, swapped=0, busy=0, filter_rst_n=0.
  - First clock edge after rst deasserts: filter_rst_n=1.
- States:
  - IDLE: busy=0.
    - commit=1 → PENDING.
    - commit and an accepted write in the same cycle: the write lands in shadow before the swap and is included in it.
  - PENDING: busy=1, waits for sample_en.
    - On an edge with sample_en=1: active <= shadow (all 3N+1... i.e. all 2N+1 coefficients at once), swapped=1 next cycle.
    - Next state: FLUSH if FLUSH_CYCLES>0, else IDLE.
    - If sample_en=1 on the same edge that commit is first seen in IDLE, the swap does NOT happen on that edge; it needs a later sample_en in PENDING.
  - FLUSH: busy=1, filter_rst_n=0 for exactly FLUSH_CYCLES cycles, starting the cycle after the swap edge.
    - Down-counter loaded with FLUSH_CYCLES-1 on entry; exits to IDLE when it reaches 0.
    - filter_rst_n returns to 1 in the first IDLE cycle.
- commit while PENDING or FLUSH: ignored, not queued.
- Shadow contents persist after a swap. Re-commit without writes re-applies the same set.
- Packed outputs are registered and change only on the swap edge or at reset. No partial updates are ever visible.
- Reset mid-PENDING or mid-FLUSH: immediate return to pass-through defaults. Pending commit discarded.
- All outputs registered except wr_ready.

Test Plan:
- Reset release, N=2, Q=14 → packed_b = {0,0,0x4000}, packed_a = 0. filter_rst_n 0 during rst, 1 one edge after release. busy=0, wr_ready=1.
- Write a0=0xC000, a1=0x2000, b0..b2=0x1000, then commit; sample_en pulsed 5 cycles later → outputs unchanged until that edge. Then packed_a={0x2000,0xC000}, packed_b={0x1000,0x1000,0x1000}. swapped pulse 1 cycle. filter_rst_n low for exactly 4 cycles. busy falls with filter_rst_n rise.
- wr_valid held during PENDING/FLUSH → wr_ready=0, no shadow change. Write completes in the first IDLE cycle.
- Write addr=7 with data 0x7FFF → wr_err pulse one cycle. No coefficient changes after a subsequent commit/swap.
- Same-cycle write b1=0x0123 + commit in IDLE → swap includes b1=0x0123. Second commit issued during FLUSH is ignored: no second swapped pulse.
- rst asserted mid-FLUSH (cycle 2 of 4) → outputs immediately revert to pass-through defaults, state IDLE after release. FLUSH_CYCLES=0 build: swap goes straight to IDLE and filter_rst_n never drops.
